// File: rtl/enha_pkg.sv
// Shared widths, state encoding and width helpers for the block-variance enhancement engine.
package enha_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int sum_w(input int pix_w, input int log2_blk);
    return pix_w + log2_blk;
  endfunction

  function automatic int acc_w(input int sum_width, input int aw);
    return sum_width + aw;
  endfunction

  localparam int PIX_W_DEF    = 8;
  localparam int LOG2_BLK_DEF = 6;
  localparam int DEPTH_DEF    = 64;
  localparam int RATE_W_DEF   = 2;
  localparam int ALPHA_W_DEF  = 4;
  localparam int ACC_W_DEF    = acc_w(sum_w(PIX_W_DEF, LOG2_BLK_DEF), clog2(DEPTH_DEF));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } enha_state_e;

endpackage

// File: rtl/enha_absdiff_pipe.sv
// Two-stage datapath: registered |pixel*2^LOG2_BLK - line_sum|, then accumulation.
module enha_absdiff_pipe
  import enha_pkg::*;
#(
  parameter int PIX_W    = PIX_W_DEF,
  parameter int LOG2_BLK = LOG2_BLK_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  localparam int SUM_W   = sum_w(PIX_W, LOG2_BLK)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [PIX_W-1:0] pix_i,
  input  logic [SUM_W-1:0] sum_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [SUM_W-1:0] scaled;
  logic [SUM_W-1:0] diff_d, diff_q;
  logic             vld_q;
  logic [ACC_W-1:0] acc_d, acc_q;

  assign scaled = {pix_i, {LOG2_BLK{1'b0}}};

  always_comb begin
    diff_d = (scaled >= sum_i) ? (scaled - sum_i) : (sum_i - scaled);
    acc_d  = acc_q;
    if (clr_i)      acc_d = '0;
    else if (vld_q) acc_d = acc_q + ACC_W'(diff_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      diff_q <= '0;
      vld_q  <= 1'b0;
      acc_q  <= '0;
    end else begin
      diff_q <= clr_i ? '0 : diff_d;
      vld_q  <= en_i & ~clr_i;
      acc_q  <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/enha_var_engine.sv
// Block-variance engine: line-sum memory, scan FSM and alpha-scaled rate output.
// state | meaning
// IDLE  | accept line-sum writes, wait for iStart
// SCAN  | DEPTH cycles pairing iBlockData with mem[idx]
// DRAIN | two cycles flushing the datapath
// DONE  | publish oVar/oEnhaRate with oValid
module enha_var_engine
  import enha_pkg::*;
#(
  parameter int PIX_W      = PIX_W_DEF,
  parameter int LOG2_BLK   = LOG2_BLK_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int RATE_W     = RATE_W_DEF,
  parameter int ALPHA_W    = ALPHA_W_DEF,
  localparam int SUM_W     = sum_w(PIX_W, LOG2_BLK),
  localparam int AW        = clog2(DEPTH),
  localparam int ACC_W     = acc_w(SUM_W, AW),
  localparam int RATE_OUT_W = RATE_W + ALPHA_W
) (
  input  logic                  iODCK,
  input  logic                  iRST,
  input  logic                  iWEA,
  input  logic [AW-1:0]         iWAddr,
  input  logic [SUM_W-1:0]      iPreLineSum,
  input  logic                  iStart,
  input  logic [PIX_W-1:0]      iBlockData,
  input  logic [ALPHA_W-1:0]    iAlpha,
  output logic [PIX_W-1:0]      oBpixel,
  output logic [ACC_W-1:0]      oVar,
  output logic [RATE_OUT_W-1:0] oEnhaRate,
  output logic                  oValid,
  output logic                  oBusy
);

  enha_state_e           state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic                  drain_q, drain_d;
  logic [ALPHA_W-1:0]    alpha_q, alpha_d;
  logic [PIX_W-1:0]      bpix_q;
  logic [ACC_W-1:0]      var_q, var_d;
  logic [RATE_OUT_W-1:0] rate_q, rate_d;
  logic                  valid_q, valid_d;
  logic                  acc_clr, scan_en, mem_we;
  logic [ACC_W-1:0]      acc;
  logic [SUM_W-1:0]      mem_q [DEPTH];

  // Writes only land in IDLE so the table cannot change under a running scan.
  assign mem_we = (state_q == IDLE) && iWEA && (int'(iWAddr) < DEPTH);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    alpha_d = alpha_q;
    var_d   = var_q;
    rate_d  = rate_q;
    valid_d = 1'b0;
    acc_clr = 1'b0;
    scan_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (iStart) begin
          acc_clr = 1'b1;
          idx_d   = '0;
          alpha_d = iAlpha;
          state_d = SCAN;
        end
      end
      SCAN: begin
        scan_en = 1'b1;
        if (idx_q == AW'(DEPTH - 1)) begin
          idx_d   = '0;
          drain_d = 1'b0;
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          var_d   = acc;
          rate_d  = RATE_OUT_W'(acc[ACC_W-1 -: RATE_W]) * RATE_OUT_W'(alpha_q);
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iODCK) begin
    if (iRST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drain_q <= 1'b0;
      alpha_q <= '0;
      bpix_q  <= '0;
      var_q   <= '0;
      rate_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      alpha_q <= alpha_d;
      bpix_q  <= iBlockData;
      var_q   <= var_d;
      rate_q  <= rate_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge iODCK) begin
    if (mem_we) mem_q[iWAddr] <= iPreLineSum;
  end

  enha_absdiff_pipe #(
    .PIX_W    (PIX_W),
    .LOG2_BLK (LOG2_BLK),
    .ACC_W    (ACC_W)
  ) u_pipe (
    .clk_i (iODCK),
    .rst_i (iRST),
    .clr_i (acc_clr),
    .en_i  (scan_en),
    .pix_i (iBlockData),
    .sum_i (mem_q[idx_q]),
    .acc_o (acc)
  );

  assign oBpixel   = bpix_q;
  assign oVar      = var_q;
  assign oEnhaRate = rate_q;
  assign oValid    = valid_q;
  assign oBusy     = (state_q == SCAN) || (state_q == DRAIN);

endmodule

// File: tb/tb_enha_var_engine.sv
// Randomized bench for enha_var_engine against a sum-of-absolute-differences reference model.
module tb_enha_var_engine;

  localparam int PIX_W    = 8;
  localparam int LOG2_BLK = 6;
  localparam int DEPTH    = 64;
  localparam int RATE_W   = 2;
  localparam int ALPHA_W  = 4;
  localparam int SUM_W    = 14;
  localparam int AW       = 6;
  localparam int ACC_W    = 20;

  logic                      iODCK = 1'b0;
  logic                      iRST, iWEA, iStart;
  logic [AW-1:0]             iWAddr;
  logic [SUM_W-1:0]          iPreLineSum;
  logic [PIX_W-1:0]          iBlockData;
  logic [ALPHA_W-1:0]        iAlpha;
  logic [PIX_W-1:0]          oBpixel;
  logic [ACC_W-1:0]          oVar;
  logic [RATE_W+ALPHA_W-1:0] oEnhaRate;
  logic                      oValid, oBusy;

  int n_assert = 0;
  int n_fail   = 0;
  int ref_mem [DEPTH];
  int pix     [DEPTH];

  always #5 iODCK = ~iODCK;

  enha_var_engine dut (
    .iODCK       (iODCK),
    .iRST        (iRST),
    .iWEA        (iWEA),
    .iWAddr      (iWAddr),
    .iPreLineSum (iPreLineSum),
    .iStart      (iStart),
    .iBlockData  (iBlockData),
    .iAlpha      (iAlpha),
    .oBpixel     (oBpixel),
    .oVar        (oVar),
    .oEnhaRate   (oEnhaRate),
    .oValid      (oValid),
    .oBusy       (oBusy)
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint model_var();
    longint s, a, b;
    s = 0;
    for (int k = 0; k < DEPTH; k++) begin
      a = longint'(pix[k]) * (longint'(1) << LOG2_BLK);
      b = longint'(ref_mem[k]);
      s += (a > b) ? (a - b) : (b - a);
    end
    return s;
  endfunction

  function automatic longint model_rate(input longint v, input int alpha);
    return (v >> (ACC_W - RATE_W)) * longint'(alpha);
  endfunction

  task automatic load_mem(input bit rnd, input int val);
    int d;
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge iODCK);
      d = rnd ? int'($urandom_range(0, (1 << SUM_W) - 1)) : val;
      iWEA        = 1'b1;
      iWAddr      = AW'(a);
      iPreLineSum = SUM_W'(d);
      ref_mem[a]  = d;
    end
    @(negedge iODCK);
    iWEA = 1'b0;
  endtask

  task automatic set_pix(input bit rnd, input int val);
    for (int k = 0; k < DEPTH; k++)
      pix[k] = rnd ? int'($urandom_range(0, (1 << PIX_W) - 1)) : val;
  endtask

  // inj: 0 plain, 1 iStart at k=10, 2 write addr 5 at k=20, 3 reset at k=30, 4 write addr 0 with iStart
  task automatic run_block(input string name, input int alpha, input int inj);
    longint ev, er;
    int     lat, busy, k;
    bit     got, aborted, seen;
    lat = 0; busy = 0; got = 0; aborted = 0; seen = 0;
    if (inj == 4) ref_mem[0] = 0;
    ev = model_var();
    er = model_rate(ev, alpha);
    @(negedge iODCK);
    iStart = 1'b1;
    iAlpha = ALPHA_W'(alpha);
    if (inj == 4) begin
      iWEA = 1'b1; iWAddr = '0; iPreLineSum = '0;
    end
    for (int j = 1; j <= 90 && !got && !aborted; j++) begin
      @(negedge iODCK);
      k = j - 1;
      iStart = 1'b0;
      iWEA   = 1'b0;
      if (oBusy)  busy++;
      if (oValid) begin got = 1'b1; lat = j; end
      if (k == 6) check_eq({name, " bpixel"}, longint'(oBpixel), longint'(pix[5]));
      iBlockData = (k < DEPTH) ? PIX_W'(pix[k]) : PIX_W'($urandom);
      if (inj == 1 && k == 10) begin
        iStart = 1'b1; iAlpha = ALPHA_W'(alpha ^ 5);
      end
      if (inj == 2 && k == 20) begin
        iWEA = 1'b1; iWAddr = AW'(5); iPreLineSum = SUM_W'(~ref_mem[5]);
      end
      if (inj == 3 && k == 30) begin
        iRST = 1'b1; aborted = 1'b1;
      end
    end
    if (aborted) begin
      @(negedge iODCK);
      iRST = 1'b0;
      check_eq({name, " rst var"},    longint'(oVar),      0);
      check_eq({name, " rst rate"},   longint'(oEnhaRate), 0);
      check_eq({name, " rst valid"},  longint'(oValid),    0);
      check_eq({name, " rst busy"},   longint'(oBusy),     0);
      check_eq({name, " rst bpixel"}, longint'(oBpixel),   0);
      repeat (80) begin
        @(negedge iODCK);
        if (oValid) seen = 1'b1;
      end
      check_eq({name, " no valid after abort"}, longint'(seen), 0);
      return;
    end
    check_eq({name, " valid seen"}, longint'(got),       1);
    check_eq({name, " latency"},    longint'(lat),       DEPTH + 3);
    check_eq({name, " busy"},       longint'(busy),      DEPTH + 2);
    check_eq({name, " var"},        longint'(oVar),      ev);
    check_eq({name, " rate"},       longint'(oEnhaRate), er);
    repeat (3) @(negedge iODCK);
    check_eq({name, " valid drop"}, longint'(oValid), 0);
    check_eq({name, " var hold"},   longint'(oVar),   ev);
    check_eq({name, " idle busy"},  longint'(oBusy),  0);
  endtask

  initial begin
    iRST = 1'b1; iWEA = 1'b0; iWAddr = '0; iPreLineSum = '0;
    iStart = 1'b0; iBlockData = '0; iAlpha = '0;
    repeat (3) @(negedge iODCK);
    check_eq("reset var",    longint'(oVar),      0);
    check_eq("reset rate",   longint'(oEnhaRate), 0);
    check_eq("reset valid",  longint'(oValid),    0);
    check_eq("reset busy",   longint'(oBusy),     0);
    check_eq("reset bpixel", longint'(oBpixel),   0);
    iRST = 1'b0;

    load_mem(1'b0, 6400);  set_pix(1'b0, 100); run_block("flat", 2, 0);
    load_mem(1'b0, 0);     set_pix(1'b0, 255); run_block("max", 2, 0);
    load_mem(1'b0, 0);     set_pix(1'b0, 64);  run_block("pix64", 1, 0);
    load_mem(1'b0, 16320); set_pix(1'b0, 0);   run_block("sumdir", 1, 0);

    load_mem(1'b1, 0); set_pix(1'b1, 0); run_block("restart_ign", 9, 1);
    repeat (70) @(negedge iODCK);
    check_eq("restart no second scan", longint'(oBusy) + longint'(oValid), 0);

    load_mem(1'b1, 0); set_pix(1'b1, 0); run_block("wr_drop", 7, 2);

    load_mem(1'b1, 0); set_pix(1'b1, 0); run_block("abort", 11, 3);
    run_block("after_abort", 11, 0);

    load_mem(1'b0, 6400); set_pix(1'b0, 100); pix[0] = 255;
    run_block("wr_start", 3, 4);

    for (int r = 0; r < 4; r++) begin
      load_mem(1'b1, 0);
      set_pix(1'b1, 0);
      run_block($sformatf("rand%0d", r), int'($urandom_range(0, 15)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
